// File: rtl/pipe_skid_reg.sv
// Elastic pipeline-stage register with a two-entry skid buffer.
// Registered in_ready, synchronous flush and occupancy count.
module pipe_skid_reg #(
   parameter int                 WIDTH          = 32,
   parameter logic [WIDTH-1:0]   RESET_VAL      = '0,
   parameter bit                 CLEAR_ON_EMPTY = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t           state;
   state_t           state_n;
   logic [WIDTH-1:0] main_data;
   logic [WIDTH-1:0] main_n;
   logic [WIDTH-1:0] skid_data;
   logic [WIDTH-1:0] skid_n;
   logic             main_valid;
   logic             ready_q;
   logic             in_fire;
   logic             out_fire;

   assign in_fire   = in_valid & ready_q;
   assign out_fire  = main_valid & out_ready;

   assign in_ready  = ready_q;
   assign out_valid = main_valid;
   assign out_data  = main_data;
   assign occupancy = state;

   // Next state and entry updates; state encoding equals occupancy.
   always_comb begin
      state_n = state;
      main_n  = main_data;
      skid_n  = skid_data;
      if (flush) begin
         state_n = EMPTY;
         main_n  = RESET_VAL;
         skid_n  = RESET_VAL;
      end else begin
         unique case (state)
            EMPTY: begin
               if (in_fire) begin
                  state_n = ONE;
                  main_n  = in_data;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_n = in_data;
               end else if (in_fire) begin
                  state_n = TWO;
                  skid_n  = in_data;
               end else if (out_fire) begin
                  state_n = EMPTY;
                  if (CLEAR_ON_EMPTY)
                     main_n = RESET_VAL;
               end
            end
            TWO: begin
               if (out_fire) begin
                  state_n = ONE;
                  main_n  = skid_data;
                  skid_n  = RESET_VAL;
               end
            end
            default: begin
               state_n = EMPTY;
               main_n  = RESET_VAL;
               skid_n  = RESET_VAL;
            end
         endcase
      end
   end

   // State and entries; valid/ready kept as their own flops so the
   // handshake outputs come straight from registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= EMPTY;
         main_data  <= RESET_VAL;
         skid_data  <= RESET_VAL;
         main_valid <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         state      <= state_n;
         main_data  <= main_n;
         skid_data  <= skid_n;
         main_valid <= (state_n != EMPTY);
         ready_q    <= (state_n != TWO);
      end
   end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios plus random traffic
// checked against a bounded-queue model of the stage.
module tb_pipe_skid_reg;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  occupancy;

   logic        b_rst;
   logic        b_flush;
   logic        b_in_valid;
   logic        b_in_ready;
   logic [7:0]  b_in_data;
   logic        b_out_valid;
   logic        b_out_ready;
   logic [7:0]  b_out_data;
   logic [1:0]  b_occupancy;

   pipe_skid_reg dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   pipe_skid_reg #(
      .WIDTH          (8),
      .RESET_VAL      (8'h00),
      .CLEAR_ON_EMPTY (1'b0)
   ) dut_b (
      .clk       (clk),
      .rst       (b_rst),
      .flush     (b_flush),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_data   (b_in_data),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_data  (b_out_data),
      .occupancy (b_occupancy)
   );

   int          checks = 0;
   int          errors = 0;
   logic [31:0] q[$];
   logic        acc;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] want);
      checks++;
      if (obs !== want) begin
         errors++;
         $display("FAIL %s observed %h expected %h", tag, obs, want);
      end
   endtask

   // Stage modelled as a FIFO holding at most two bundles.
   task automatic model_edge();
      int n;
      n   = q.size();
      acc = in_valid && (n < 2);
      if (!rst || flush) begin
         q.delete();
      end else begin
         if (n > 0 && out_ready)
            void'(q.pop_front());
         if (acc)
            q.push_back(in_data);
      end
   endtask

   task automatic compare();
      logic [31:0] d;
      d = (q.size() > 0) ? q[0] : 32'h0;
      check("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
      check("out_data", out_data, d);
      check("occupancy", {30'b0, occupancy}, q.size());
      check("in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      compare();
   endtask

   initial begin
      rst = 0; flush = 0; in_valid = 1; in_data = 32'hDEAD;
      out_ready = 0;
      b_rst = 0; b_flush = 0; b_in_valid = 0; b_in_data = 8'h00;
      b_out_ready = 0;
      acc = 0;

      cyc();
      cyc();
      check("rst_valid", {31'b0, out_valid}, 32'd0);
      check("rst_data", out_data, 32'd0);
      check("rst_ready", {31'b0, in_ready}, 32'd1);
      check("rst_occ", {30'b0, occupancy}, 32'd0);
      rst = 1; b_rst = 1; in_valid = 0;
      cyc();

      out_ready = 1;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1; in_data = i;
         cyc();
         check("stream_data", out_data, i);
         check("stream_occ", {30'b0, occupancy}, 32'd1);
      end
      in_valid = 0;
      cyc();
      check("drain_clear", out_data, 32'd0);

      out_ready = 0; in_valid = 1; in_data = 32'hA;
      cyc();
      in_data = 32'hB;
      cyc();
      check("bp_occ", {30'b0, occupancy}, 32'd2);
      check("bp_ready", {31'b0, in_ready}, 32'd0);
      check("bp_head", out_data, 32'hA);
      in_valid = 0; out_ready = 1;
      cyc();
      check("bp_second", out_data, 32'hB);
      check("bp_ready_back", {31'b0, in_ready}, 32'd1);
      cyc();
      check("bp_empty", {31'b0, out_valid}, 32'd0);

      out_ready = 0; in_valid = 1; in_data = 32'h1;
      cyc();
      in_data = 32'h2;
      cyc();
      flush = 1; in_data = 32'hC;
      cyc();
      check("fl_valid", {31'b0, out_valid}, 32'd0);
      check("fl_occ", {30'b0, occupancy}, 32'd0);
      check("fl_data", out_data, 32'd0);
      flush = 0; in_valid = 0;
      cyc();
      check("fl_no_c", {31'b0, out_valid}, 32'd0);

      in_valid = 1; in_data = 32'h5;
      cyc();
      out_ready = 1; in_data = 32'h6;
      cyc();
      check("sim_data", out_data, 32'h6);
      check("sim_occ", {30'b0, occupancy}, 32'd1);
      in_valid = 0;
      cyc();

      b_in_valid = 1; b_in_data = 8'h7F;
      cyc();
      check("b_load", {24'b0, b_out_data}, 32'h7F);
      check("b_valid", {31'b0, b_out_valid}, 32'd1);
      b_in_valid = 0; b_out_ready = 1;
      cyc();
      check("b_drained", {31'b0, b_out_valid}, 32'd0);
      check("b_keep", {24'b0, b_out_data}, 32'h7F);
      b_flush = 1;
      cyc();
      check("b_flush", {24'b0, b_out_data}, 32'h00);
      b_flush = 0;

      acc = 1;
      for (int i = 0; i < 800; i++) begin
         rst       = ($urandom_range(63) != 0);
         flush     = ($urandom_range(15) == 0);
         out_ready = ($urandom_range(3) != 0) && (i % 100 < 70);
         if (!in_valid || acc) begin
            in_valid = $urandom_range(2) != 0;
            in_data  = $urandom;
         end
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
